pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter ADDR_W, default 32: width of the stage PC field.
REQ-002 Parameter DATA_W, default 32: width of the stage payload (instruction or operand bundle).
REQ-003 Parameter STALL_W, default 6: width of the controller stall vector.
REQ-004 Parameter STAGE, default 1: index of this stage's bit in ctrl_stall; the downstream bit is STAGE+1.
REQ-005 Parameter CNT_W, default 16: width of each statistics counter.
REQ-006 The block SHALL have one clock and a synchronous, active-high reset; ports are named clk and rst.
REQ-007 clk  in  1  rising-edge clock.
REQ-008 rst  in  1  synchronous reset, active-high.
REQ-009 in_pc  in  ADDR_W  upstream PC.
REQ-010 in_data  in  DATA_W  upstream payload.
REQ-011 in_valid  in  1  upstream payload is a real operation.
REQ-012 ctrl_stall  in  STALL_W  per-stage stall vector (1 = stall).
REQ-013 flush  in  1  kill the stage contents (branch redirect or exception).
REQ-014 out_pc  out  ADDR_W  registered PC.
REQ-015 out_data  out  DATA_W  registered payload.
REQ-016 out_valid  out  1  registered valid.
REQ-017 stat_clr, stat_stall_cnt, stat_bubble_cnt, stat_flush_cnt  in 1 / out CNT_W x3: present only per REQ-030.

Function
REQ-018 Let S = ctrl_stall[STAGE] and D = ctrl_stall[STAGE+1]; when STAGE = STALL_W-1, D SHALL be taken as 0.
REQ-019 Per cycle, actions SHALL be evaluated in strict priority: rst > flush > bubble > hold > advance.
REQ-020 Flush: out_pc, out_data <= 0; out_valid <= 0, regardless of S and D.
REQ-021 Bubble (S=1, D=0): out_pc, out_data <= 0; out_valid <= 0.
REQ-022 Hold (S=1, D=1): all outputs SHALL retain their values.
REQ-023 Advance (S=0): out_pc <= in_pc, out_data <= in_data, out_valid <= in_valid; latency exactly one cycle.
REQ-024 S=0 with D=1 (controller-illegal) SHALL be treated as advance; no assertion or error output.
REQ-025 A zero-payload advance with in_valid=1 SHALL produce out_valid=1, so a bubble and a real all-zero operation are distinguishable.
REQ-026 Outputs SHALL be driven directly from flops; no combinational input-to-output path.

Reset
REQ-027 On rst=1 at a rising edge: out_pc, out_data = 0; out_valid = 0; all statistics counters = 0.
REQ-028 rst asserted during hold, flush or bubble SHALL override; the first cycle after deassertion SHALL follow normal priority.

Configuration
REQ-029 Macro PIPE_STAGE_STAT_EN SHALL gate the statistics feature.
REQ-030 Defined: stat_clr input and three CNT_W counter outputs exist. stat_stall_cnt increments on hold cycles, stat_bubble_cnt on bubble cycles, stat_flush_cnt on flush cycles. Counters saturate at all-ones. stat_clr=1 clears all three synchronously, taking priority over an increment in the same cycle.
REQ-031 Undefined: the statistics ports and logic SHALL be absent; datapath behaviour is identical.

Structure
REQ-032 The shared package pipe_pkg SHALL hold the STALL_ENABLE/STALL_DISABLE levels, the ZERO_WORD constant and the default ADDR_W/DATA_W/STALL_W values.
REQ-033 One sub-module, pipe_sat_cnt (a saturating counter with clear and increment enable), SHALL be instantiated three times under PIPE_STAGE_STAT_EN.
REQ-034 Elaboration SHALL fail if STAGE >= STALL_W.

Verification
REQ-035 Advance: in_pc=0x100, in_data=0x2402_0005, in_valid=1, ctrl_stall=0 -> the next cycle shows out_pc=0x100, out_data=0x2402_0005, out_valid=1.
REQ-036 Hold, then bubble, with STAGE=1: ctrl_stall=6'b000110 for 3 cycles with changing inputs -> outputs frozen; then ctrl_stall=6'b000010 -> outputs 0, out_valid=0 next cycle, stat_bubble_cnt=1, stat_stall_cnt=3.
REQ-037 Flush priority: flush=1 together with ctrl_stall=6'b000110 and valid contents held -> outputs 0, out_valid=0, stat_flush_cnt=1, stat_stall_cnt unchanged.
REQ-038 Last stage: STAGE=5, STALL_W=6, ctrl_stall=6'b100000 -> bubble inserted (D treated as 0).
REQ-039 Saturation and clear: CNT_W=4 with 20 hold cycles -> stat_stall_cnt=15; then stat_clr=1 together with a hold cycle -> 0.
REQ-040 Reset mid-hold: rst=1 during ctrl_stall=6'b000110 with out_valid=1 -> all outputs and counters 0; after deassertion with ctrl_stall=0 -> advance resumes next cycle.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register and its helpers.
// Holds the stall level encoding, the zero word used to clear stage
// contents, the default field widths and the per-cycle action encoding.
package pipe_pkg;

   localparam int DEFAULT_ADDR_W  = 32;
   localparam int DEFAULT_DATA_W  = 32;
   localparam int DEFAULT_STALL_W = 6;
   localparam int DEFAULT_CNT_W   = 16;

   localparam logic STALL_ENABLE  = 1'b1;
   localparam logic STALL_DISABLE = 1'b0;

   localparam logic [63:0] ZERO_WORD = 64'h0;

   typedef enum logic [1:0] {
      ACT_ADVANCE = 2'd0,
      ACT_HOLD    = 2'd1,
      ACT_BUBBLE  = 2'd2,
      ACT_FLUSH   = 2'd3
   } stage_action_e;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Bundle of upstream inputs, controller signals and registered outputs of
// one pipeline stage. The statistics signals exist only when
// PIPE_STAGE_STAT_EN is defined.
interface pipe_stage_reg_if #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int STALL_W = 6,
   parameter int CNT_W   = 16
);

   logic [ADDR_W-1:0]  in_pc;
   logic [DATA_W-1:0]  in_data;
   logic               in_valid;
   logic [STALL_W-1:0] ctrl_stall;
   logic               flush;
   logic [ADDR_W-1:0]  out_pc;
   logic [DATA_W-1:0]  out_data;
   logic               out_valid;

`ifdef PIPE_STAGE_STAT_EN
   logic               stat_clr;
   logic [CNT_W-1:0]   stat_stall_cnt;
   logic [CNT_W-1:0]   stat_bubble_cnt;
   logic [CNT_W-1:0]   stat_flush_cnt;

   modport master (
      output in_pc, in_data, in_valid, ctrl_stall, flush, stat_clr,
      input  out_pc, out_data, out_valid,
             stat_stall_cnt, stat_bubble_cnt, stat_flush_cnt
   );

   modport slave (
      input  in_pc, in_data, in_valid, ctrl_stall, flush, stat_clr,
      output out_pc, out_data, out_valid,
             stat_stall_cnt, stat_bubble_cnt, stat_flush_cnt
   );
`else
   modport master (
      output in_pc, in_data, in_valid, ctrl_stall, flush,
      input  out_pc, out_data, out_valid
   );

   modport slave (
      input  in_pc, in_data, in_valid, ctrl_stall, flush,
      output out_pc, out_data, out_valid
   );
`endif

endinterface

// File: rtl/pipe_sat_cnt.sv
// Saturating event counter: sticks at all-ones, clear beats increment,
// reset beats everything.
module pipe_sat_cnt #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Next count: clear first, otherwise count up unless already saturated.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   // Count register with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with flush, bubble insertion and hold driven by
// the controller stall vector. Priority per cycle is
// reset > flush > bubble > hold > advance. Optional hold/bubble/flush
// statistics counters are built when PIPE_STAGE_STAT_EN is defined.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int ADDR_W  = DEFAULT_ADDR_W,
   parameter int DATA_W  = DEFAULT_DATA_W,
   parameter int STALL_W = DEFAULT_STALL_W,
   parameter int STAGE   = 1,
   parameter int CNT_W   = DEFAULT_CNT_W
) (
   input logic              clk,
   input logic              rst,
   pipe_stage_reg_if.slave  bus
);

   localparam logic [ADDR_W-1:0] PC_ZERO   = ADDR_W'(ZERO_WORD);
   localparam logic [DATA_W-1:0] DATA_ZERO = DATA_W'(ZERO_WORD);

   if (STAGE >= STALL_W) begin : gen_bad_stage
      $error("pipe_stage_reg: STAGE must be below STALL_W");
   end
   if (CNT_W < 1) begin : gen_bad_cnt
      $error("pipe_stage_reg: CNT_W must be at least 1");
   end

   logic              stallSelf;
   logic              stallDown;
   stage_action_e     action;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              valid_q, valid_d;

   assign stallSelf = bus.ctrl_stall[STAGE];

   // The last stage has nothing downstream, so it never sees a downstream stall.
   if (STAGE == STALL_W - 1) begin : gen_last_stage
      assign stallDown = STALL_DISABLE;
   end else begin : gen_mid_stage
      assign stallDown = bus.ctrl_stall[STAGE+1];
   end

   // Resolve this cycle's action; S=0 with D=1 falls through to advance.
   always_comb begin
      action = ACT_ADVANCE;
      if (bus.flush) begin
         action = ACT_FLUSH;
      end else if ((stallSelf == STALL_ENABLE) && (stallDown == STALL_DISABLE)) begin
         action = ACT_BUBBLE;
      end else if ((stallSelf == STALL_ENABLE) && (stallDown == STALL_ENABLE)) begin
         action = ACT_HOLD;
      end
   end

   // Next stage contents for the chosen action; flush and bubble both empty the stage.
   always_comb begin
      pc_d    = pc_q;
      data_d  = data_q;
      valid_d = valid_q;
      case (action)
         ACT_FLUSH, ACT_BUBBLE: begin
            pc_d    = PC_ZERO;
            data_d  = DATA_ZERO;
            valid_d = 1'b0;
         end
         ACT_HOLD: begin
            pc_d    = pc_q;
            data_d  = data_q;
            valid_d = valid_q;
         end
         default: begin
            pc_d    = bus.in_pc;
            data_d  = bus.in_data;
            valid_d = bus.in_valid;
         end
      endcase
   end

   // Stage register; reset overrides any action in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q    <= PC_ZERO;
         data_q  <= DATA_ZERO;
         valid_q <= 1'b0;
      end else begin
         pc_q    <= pc_d;
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

   assign bus.out_pc    = pc_q;
   assign bus.out_data  = data_q;
   assign bus.out_valid = valid_q;

`ifdef PIPE_STAGE_STAT_EN
   pipe_sat_cnt #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr_i (bus.stat_clr),
      .inc_i (action == ACT_HOLD),
      .cnt_o (bus.stat_stall_cnt)
   );

   pipe_sat_cnt #(.W(CNT_W)) u_bubble_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr_i (bus.stat_clr),
      .inc_i (action == ACT_BUBBLE),
      .cnt_o (bus.stat_bubble_cnt)
   );

   pipe_sat_cnt #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr_i (bus.stat_clr),
      .inc_i (action == ACT_FLUSH),
      .cnt_o (bus.stat_flush_cnt)
   );
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: a mid-pipe stage (STAGE=1, 4-bit
// counters) and a last stage (STAGE=5). Statistics checks are compiled
// only when PIPE_STAGE_STAT_EN is defined.
module tb_pipe_stage_reg;

   logic clk;
   logic rst;
   int   passCount;
   int   checkCount;

   pipe_stage_reg_if #(.ADDR_W(32), .DATA_W(32), .STALL_W(6), .CNT_W(4))  bus1 ();
   pipe_stage_reg_if #(.ADDR_W(32), .DATA_W(32), .STALL_W(6), .CNT_W(16)) bus5 ();

   pipe_stage_reg #(.ADDR_W(32), .DATA_W(32), .STALL_W(6), .STAGE(1), .CNT_W(4)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (bus1)
   );

   pipe_stage_reg #(.ADDR_W(32), .DATA_W(32), .STALL_W(6), .STAGE(5), .CNT_W(16)) dut5 (
      .clk (clk),
      .rst (rst),
      .bus (bus5)
   );

   // Free-running clock, 10 ns period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkValue(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checkCount++;
      assert (observed === expected) begin
         passCount++;
      end else begin
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] data, input logic valid,
                                input logic [5:0] stall, input logic fl);
      bus1.in_pc      = pc;
      bus1.in_data    = data;
      bus1.in_valid   = valid;
      bus1.ctrl_stall = stall;
      bus1.flush      = fl;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] pc, input logic [31:0] data, input logic valid);
      checkValue({tag, ".pc"},    64'(bus1.out_pc),    64'(pc));
      checkValue({tag, ".data"},  64'(bus1.out_data),  64'(data));
      checkValue({tag, ".valid"}, 64'(bus1.out_valid), 64'(valid));
   endtask

   task automatic checkLast(input string tag, input logic [31:0] pc, input logic [31:0] data, input logic valid);
      checkValue({tag, ".pc"},    64'(bus5.out_pc),    64'(pc));
      checkValue({tag, ".data"},  64'(bus5.out_data),  64'(data));
      checkValue({tag, ".valid"}, 64'(bus5.out_valid), 64'(valid));
   endtask

`ifdef PIPE_STAGE_STAT_EN
   task automatic checkStat(input string tag, input logic [3:0] stallCnt, input logic [3:0] bubbleCnt,
                            input logic [3:0] flushCnt);
      checkValue({tag, ".stall_cnt"},  64'(bus1.stat_stall_cnt),  64'(stallCnt));
      checkValue({tag, ".bubble_cnt"}, 64'(bus1.stat_bubble_cnt), 64'(bubbleCnt));
      checkValue({tag, ".flush_cnt"},  64'(bus1.stat_flush_cnt),  64'(flushCnt));
   endtask
`endif

   // Directed sequence; inputs change 1 ns after a rising edge and are
   // checked 1 ns after the following edge.
   initial begin
      passCount  = 0;
      checkCount = 0;
      rst        = 1'b1;
      applyStimulus(32'h0, 32'h0, 1'b0, 6'b000000, 1'b0);
      bus5.in_pc      = '0;
      bus5.in_data    = '0;
      bus5.in_valid   = 1'b0;
      bus5.ctrl_stall = '0;
      bus5.flush      = 1'b0;
`ifdef PIPE_STAGE_STAT_EN
      bus1.stat_clr = 1'b0;
      bus5.stat_clr = 1'b0;
`endif
      $display("[TB] reset");
      tick();
      tick();
      checkOutput("reset", 32'h0, 32'h0, 1'b0);
      checkLast("reset_last", 32'h0, 32'h0, 1'b0);
`ifdef PIPE_STAGE_STAT_EN
      checkStat("reset", 4'd0, 4'd0, 4'd0);
`endif
      rst = 1'b0;

      // Last stage: advance, then a self stall becomes a bubble.
      bus5.in_pc    = 32'h0000_00A0;
      bus5.in_data  = 32'h0000_0005;
      bus5.in_valid = 1'b1;
      tick();
      checkLast("last_advance", 32'h0000_00A0, 32'h0000_0005, 1'b1);
      bus5.ctrl_stall = 6'b100000;
      tick();
      checkLast("last_bubble", 32'h0, 32'h0, 1'b0);
`ifdef PIPE_STAGE_STAT_EN
      checkValue("last_bubble.bubble_cnt", 64'(bus5.stat_bubble_cnt), 64'd1);
      checkValue("last_bubble.stall_cnt",  64'(bus5.stat_stall_cnt),  64'd0);
`endif
      bus5.ctrl_stall = 6'b000000;

      // Plain advance with one-cycle latency.
      $display("[TB] advance");
      applyStimulus(32'h0000_0100, 32'h2402_0005, 1'b1, 6'b000000, 1'b0);
      tick();
      checkOutput("advance", 32'h0000_0100, 32'h2402_0005, 1'b1);

      // All-zero real operation keeps valid high.
      applyStimulus(32'h0, 32'h0, 1'b1, 6'b000000, 1'b0);
      tick();
      checkOutput("zero_op", 32'h0, 32'h0, 1'b1);

      applyStimulus(32'h0000_0100, 32'h2402_0005, 1'b1, 6'b000000, 1'b0);
      tick();
      checkOutput("reload", 32'h0000_0100, 32'h2402_0005, 1'b1);

      // Hold three cycles with changing inputs, then bubble.
      $display("[TB] hold then bubble");
      for (int i = 0; i < 3; i++) begin
         applyStimulus(32'h0000_0200 + 32'(i), 32'hDEAD_0000 + 32'(i), 1'(i % 2), 6'b000110, 1'b0);
         tick();
         checkOutput("hold", 32'h0000_0100, 32'h2402_0005, 1'b1);
      end
      applyStimulus(32'h0000_0210, 32'h1111_2222, 1'b1, 6'b000010, 1'b0);
      tick();
      checkOutput("bubble", 32'h0, 32'h0, 1'b0);
`ifdef PIPE_STAGE_STAT_EN
      checkStat("bubble", 4'd3, 4'd1, 4'd0);
`endif

      // S=0 with D=1 still advances.
      applyStimulus(32'h0000_0300, 32'h0000_ABCD, 1'b1, 6'b000100, 1'b0);
      tick();
      checkOutput("illegal_adv", 32'h0000_0300, 32'h0000_ABCD, 1'b1);

      // Flush beats a hold request.
      $display("[TB] flush priority");
      applyStimulus(32'h0000_0400, 32'h0000_4444, 1'b1, 6'b000000, 1'b0);
      tick();
      checkOutput("pre_flush", 32'h0000_0400, 32'h0000_4444, 1'b1);
      applyStimulus(32'h0000_0404, 32'h0000_5555, 1'b1, 6'b000110, 1'b0);
      tick();
      checkOutput("pre_flush_hold", 32'h0000_0400, 32'h0000_4444, 1'b1);
      applyStimulus(32'h0000_0408, 32'h0000_6666, 1'b1, 6'b000110, 1'b1);
      tick();
      checkOutput("flush", 32'h0, 32'h0, 1'b0);
`ifdef PIPE_STAGE_STAT_EN
      checkStat("flush", 4'd4, 4'd1, 4'd1);
`endif

      // Counter saturation, then clear in the same cycle as a hold.
      $display("[TB] saturation and clear");
      applyStimulus(32'h0000_0500, 32'h0000_7777, 1'b1, 6'b000110, 1'b0);
      for (int i = 0; i < 20; i++) begin
         tick();
      end
      checkOutput("sat_hold", 32'h0, 32'h0, 1'b0);
`ifdef PIPE_STAGE_STAT_EN
      checkStat("saturate", 4'd15, 4'd1, 4'd1);
      bus1.stat_clr = 1'b1;
      tick();
      checkStat("clear", 4'd0, 4'd0, 4'd0);
      bus1.stat_clr = 1'b0;
`endif

      // Reset in the middle of a hold with valid contents.
      $display("[TB] reset mid-hold");
      applyStimulus(32'h0000_0500, 32'h0000_8888, 1'b1, 6'b000000, 1'b0);
      tick();
      checkOutput("pre_reset", 32'h0000_0500, 32'h0000_8888, 1'b1);
      applyStimulus(32'h0000_0504, 32'h0000_9999, 1'b1, 6'b000110, 1'b0);
      tick();
`ifdef PIPE_STAGE_STAT_EN
      checkStat("pre_reset", 4'd1, 4'd0, 4'd0);
`endif
      rst = 1'b1;
      tick();
      checkOutput("reset_hold", 32'h0, 32'h0, 1'b0);
`ifdef PIPE_STAGE_STAT_EN
      checkStat("reset_hold", 4'd0, 4'd0, 4'd0);
`endif
      rst = 1'b0;
      applyStimulus(32'h0000_0600, 32'h0000_0077, 1'b1, 6'b000000, 1'b0);
      tick();
      checkOutput("post_reset", 32'h0000_0600, 32'h0000_0077, 1'b1);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
